// File: rtl/mem_stage_unit_pkg.sv
// Shared CPU constants and types for the memory stage: data/register widths,
// bus timeout default and the memory-access FSM state encoding.
package mem_stage_unit_pkg;

    localparam int DATA_W          = 16;
    localparam int REG_IDX_W       = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Counter width able to hold values up to and including limit.
    function automatic int ctr_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_stage_unit_timeout.sv
// Bus-wait timeout counter: cleared on entry to WAIT, counts stalled WAIT cycles,
// and flags expiry during the LIMIT-th stalled WAIT cycle.
module mem_timeout_ctr
    import mem_stage_unit_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = ctr_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    // Expiry is the edge at which the count would step onto LIMIT.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_stage_unit.sv
// Pipeline MEM stage: data-memory handshake with stall/timeout, branch resolution
// and the MEM/WB result register.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    mem_alu_result,
    input  logic [DATA_W-1:0]    mem_rs2_data,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_branch_target,
    input  logic                 mem_reg_write,
    input  logic                 mem_mem_read,
    input  logic                 mem_mem_write,
    input  logic                 mem_mem_to_reg,
    input  logic                 mem_branch,
    input  logic                 mem_branch_ne,
    input  logic                 mem_zero,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 stall_mem,
    output logic                 branch_taken,
    output logic [DATA_W-1:0]    redirect_pc,
    output logic [DATA_W-1:0]    wb_result,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic                 wb_reg_write,
    output logic                 bus_error
);

    mem_state_e state, state_nxt;

    logic access;
    logic in_wait;
    logic req_int;
    logic stall_int;
    logic ctr_clear;
    logic ctr_enable;
    logic timeout_fire;
    logic load_wb;
    logic use_rdata;

    assign access    = mem_mem_read | mem_mem_write;
    assign in_wait   = (state == ST_WAIT);
    assign req_int   = (~in_wait & access) | in_wait;
    assign stall_int = req_int & ~dmem_ack;

    // Port-level views are forced low during reset so the bus request drops at once.
    assign dmem_req     = req_int & ~rst;
    assign stall_mem    = stall_int & ~rst;
    assign dmem_we      = mem_mem_write;
    assign dmem_addr    = mem_alu_result;
    assign dmem_wdata   = mem_rs2_data;
    assign redirect_pc  = mem_branch_target;
    assign branch_taken = ((mem_branch & mem_zero) | (mem_branch_ne & ~mem_zero)) & ~stall_mem;

    assign ctr_enable = in_wait & ~dmem_ack;

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (timeout_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && !dmem_ack) begin
                    state_nxt = ST_WAIT;
                    ctr_clear = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || timeout_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A write wins over a read, so store data never reaches the register file.
    assign use_rdata = mem_mem_read & mem_mem_to_reg & ~mem_mem_write;
    assign load_wb   = ~stall_int | timeout_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_result    <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            if (load_wb) begin
                wb_result    <= use_rdata ? dmem_rdata : mem_alu_result;
                wb_rd        <= mem_rd;
                wb_reg_write <= mem_reg_write & ~timeout_fire;
            end
            if (timeout_fire) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: open-loop driver pushes predicted responses,
// a negedge monitor pops and compares per cycle and at each MEM/WB retirement.
module tb_mem_stage_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_alu_result = '0, mem_rs2_data = '0, mem_branch_target = '0;
    logic [3:0]  mem_rd = '0;
    logic        mem_reg_write = 0, mem_mem_read = 0, mem_mem_write = 0, mem_mem_to_reg = 0;
    logic        mem_branch = 0, mem_branch_ne = 0, mem_zero = 0;
    logic        dmem_req, dmem_we, dmem_ack = 0;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        stall_mem, branch_taken;
    logic [15:0] redirect_pc, wb_result;
    logic [3:0]  wb_rd;
    logic        wb_reg_write, bus_error;

    mem_stage_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
        .mem_branch_target(mem_branch_target), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_branch(mem_branch),
        .mem_branch_ne(mem_branch_ne), .mem_zero(mem_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .branch_taken(branch_taken), .redirect_pc(redirect_pc),
        .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu, rs2, tgt, rdata;
        logic [3:0]  rd;
        logic        rw, mr, mw, m2r, br, bne, z;
        int          delay;
        bit          tmo;
        int          nop_len;
    } item_t;

    typedef struct {
        bit          access;
        logic        we;
        logic [15:0] addr, wdata, tgt;
        logic        br;
        int          len, n_stall;
        logic [15:0] wb_result;
        logic [3:0]  wb_rd;
        logic        wb_rw;
        logic        bus_before, bus_after;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   model_bus = 0;
    bit   mon_en = 1;
    bit   cur_active = 0;
    bit   have_ret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic item_t nop_item();
        item_t it = '{default: 0};
        it.nop_len = 1;
        return it;
    endfunction

    function automatic item_t rand_item();
        item_t it = nop_item();
        int kind = $urandom_range(0, 9);
        it.alu = 16'($urandom); it.rs2 = 16'($urandom);
        it.tgt = 16'($urandom); it.rdata = 16'($urandom);
        it.rd = 4'($urandom); it.rw = 1'($urandom);
        it.br = 1'($urandom); it.bne = 1'($urandom); it.z = 1'($urandom);
        it.m2r = 1'($urandom);
        it.mr = (kind >= 3 && kind <= 5) || kind == 8 || (kind == 9 && it.m2r);
        it.mw = (kind == 6 || kind == 7 || kind == 8) || (kind == 9 && !it.m2r);
        if (kind >= 3 && kind <= 5) it.m2r = ($urandom_range(0, 3) != 0);
        it.delay = $urandom_range(0, TMO);
        it.tmo = (kind == 9);
        it.nop_len = $urandom_range(1, 2);
        return it;
    endfunction

    // Model: expected bus view, stall count and MEM/WB contents of one instruction.
    task automatic drive_item(input item_t it);
        exp_t e;
        bit   acc;
        bit   last;
        acc = it.mr | it.mw;
        e.access = acc; e.we = it.mw; e.addr = it.alu; e.wdata = it.rs2; e.tgt = it.tgt;
        e.br = (it.br & it.z) | (it.bne & ~it.z);
        if (!acc) begin
            e.len = it.nop_len; e.n_stall = 0;
        end else if (it.tmo) begin
            e.len = TMO + 1; e.n_stall = TMO + 1;
        end else begin
            e.len = it.delay + 1; e.n_stall = it.delay;
        end
        e.wb_result = (it.mr && it.m2r && !it.mw) ? it.rdata : it.alu;
        e.wb_rd = it.rd;
        e.wb_rw = it.rw & ~(acc & it.tmo);
        e.bus_before = model_bus;
        if (acc && it.tmo) model_bus = 1;
        e.bus_after = model_bus;
        exp_q.push_back(e);
        mem_alu_result = it.alu; mem_rs2_data = it.rs2; mem_rd = it.rd;
        mem_branch_target = it.tgt; mem_reg_write = it.rw; mem_mem_read = it.mr;
        mem_mem_write = it.mw; mem_mem_to_reg = it.m2r; mem_branch = it.br;
        mem_branch_ne = it.bne; mem_zero = it.z;
        for (int c = 0; c < e.len; c++) begin
            last = (c == e.len - 1);
            if (acc) begin
                dmem_ack   = last && !it.tmo;
                dmem_rdata = last ? it.rdata : 16'($urandom);
            end else begin
                dmem_ack   = 1'($urandom);
                dmem_rdata = 16'($urandom);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_idle();
        item_t it = nop_item();
        mem_alu_result = it.alu; mem_rs2_data = it.rs2; mem_rd = it.rd;
        mem_branch_target = it.tgt; mem_reg_write = 0; mem_mem_read = 0;
        mem_mem_write = 0; mem_mem_to_reg = 0; mem_branch = 0;
        mem_branch_ne = 0; mem_zero = 0; dmem_ack = 0;
    endtask

    // Monitor
    initial begin
        exp_t        cur, ret;
        int          cyc;
        bit          stall_exp;
        logic [15:0] lw_result = '0;
        logic [3:0]  lw_rd = '0;
        logic        lw_rw = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (have_ret) begin
                chk("wb_result", wb_result, ret.wb_result);
                chk("wb_rd", wb_rd, ret.wb_rd);
                chk("wb_reg_write", wb_reg_write, ret.wb_rw);
                chk("bus_error_after", bus_error, ret.bus_after);
                lw_result = ret.wb_result; lw_rd = ret.wb_rd; lw_rw = ret.wb_rw;
                have_ret = 0;
            end
            if (!cur_active && mon_en && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                cyc = 0;
                cur_active = 1;
            end
            if (cur_active) begin
                stall_exp = (cyc < cur.n_stall);
                chk("stall_mem", stall_mem, stall_exp);
                chk("dmem_req", dmem_req, cur.access);
                chk("dmem_we", dmem_we, cur.we);
                chk("dmem_addr", dmem_addr, cur.addr);
                chk("dmem_wdata", dmem_wdata, cur.wdata);
                chk("redirect_pc", redirect_pc, cur.tgt);
                chk("branch_taken", branch_taken, cur.br & ~stall_exp);
                chk("bus_error_hold", bus_error, cur.bus_before);
                if (cyc <= cur.n_stall) begin
                    chk("wb_result_hold", wb_result, lw_result);
                    chk("wb_rd_hold", wb_rd, lw_rd);
                    chk("wb_rw_hold", wb_reg_write, lw_rw);
                end
                cyc++;
                if (cyc == cur.len) begin
                    ret = cur;
                    have_ret = 1;
                    cur_active = 0;
                end
            end
        end
    end

    initial begin
        item_t it;
        int    guard;
        #3;
        chk("rst_wb_result", wb_result, 16'h0);
        chk("rst_wb_rd", wb_rd, 4'h0);
        chk("rst_wb_rw", wb_reg_write, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        it = nop_item(); it.rd = 4'd3; it.alu = 16'h1234; it.rw = 1;
        drive_item(it);
        it = nop_item(); it.mr = 1; it.m2r = 1; it.rw = 1; it.rd = 4'd5;
        it.alu = 16'h0040; it.delay = 3; it.rdata = 16'hBEEF;
        drive_item(it);
        it = nop_item(); it.mw = 1; it.alu = 16'h0010; it.rs2 = 16'h00AA; it.delay = 0;
        drive_item(it);
        it = nop_item(); it.bne = 1; it.z = 0; it.tgt = 16'h0200;
        drive_item(it);
        it.z = 1;
        drive_item(it);
        it = nop_item(); it.mr = 1; it.m2r = 1; it.rw = 1; it.rd = 4'd9;
        it.alu = 16'h0300; it.delay = TMO; it.rdata = 16'hCAFE;
        drive_item(it);
        it = nop_item(); it.mr = 1; it.m2r = 1; it.rw = 1; it.rd = 4'd6;
        it.alu = 16'h0080; it.tmo = 1; it.rdata = 16'h7777;
        drive_item(it);

        for (int n = 0; n < 250; n++) drive_item(rand_item());

        drive_idle();
        guard = 0;
        while ((cur_active || have_ret || exp_q.size() > 0) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_timeout", guard < 50, 1'b1);
        mon_en = 0;

        // Reset in the second WAIT cycle of a stalled load.
        mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
        mem_rd = 4'd7; mem_alu_result = 16'h0100; dmem_ack = 0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1;
        #1;
        chk("rstw_dmem_req", dmem_req, 1'b0);
        chk("rstw_stall", stall_mem, 1'b0);
        chk("rstw_wb_result", wb_result, 16'h0);
        chk("rstw_wb_rd", wb_rd, 4'h0);
        chk("rstw_wb_rw", wb_reg_write, 1'b0);
        chk("rstw_bus_error", bus_error, 1'b0);
        @(posedge clk); #1;
        drive_idle();
        mem_alu_result = 16'h5555; mem_rd = 4'd2;
        dmem_ack = 1; dmem_rdata = 16'hDEAD;
        #2 rst = 0;
        #1;
        chk("post_rst_req", dmem_req, 1'b0);
        chk("post_rst_stall", stall_mem, 1'b0);
        @(posedge clk); #1;
        chk("ack_ignored_result", wb_result, 16'h5555);
        chk("ack_ignored_rd", wb_rd, 4'd2);
        chk("ack_ignored_rw", wb_reg_write, 1'b0);
        chk("ack_ignored_bus", bus_error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
